// File: rtl/flag_register_unit_if.sv
// Bus bundle between the ALU issue stage and the flags unit: operation, operands,
// write controls and exception pulses in, ALU result and flag state out.
interface flag_register_unit_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             shift_carry;
    logic [1:0]       flag_w;
    logic             cond_ex;
    logic             stall;
    logic             exc_entry;
    logic             exc_return;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [3:0]       saved_flags;
    logic             saved_valid;
    logic             exc_err;

    modport master (
        output alu_ctrl, src_a, src_b, shift_carry, flag_w, cond_ex, stall,
               exc_entry, exc_return,
        input  result, flags, saved_flags, saved_valid, exc_err
    );

    modport slave (
        input  alu_ctrl, src_a, src_b, shift_carry, flag_w, cond_ex, stall,
               exc_entry, exc_return,
        output result, flags, saved_flags, saved_valid, exc_err
    );
endinterface

// File: rtl/flag_register_unit.sv
// ALU plus architectural N/Z/C/V register with condition-gated group writes and a
// one-deep saved copy used across exception entry and return.
module flag_register_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flag_register_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_MOV = 3'b101,
        OP_ADC = 3'b110,
        OP_SBC = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    flags_t           flags_q, flags_d;
    flags_t           saved_flags_q, saved_flags_d;
    logic             saved_valid_q, saved_valid_d;
    logic             exc_err_q, exc_err_d;

    alu_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] result_w;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic             is_arith;
    flags_t           alu_flags;

    assign op = alu_op_e'(bus.alu_ctrl);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        b_eff    = bus.src_b;
        cin      = 1'b0;
        is_arith = 1'b1;
        unique case (op)
            OP_ADD: ;
            OP_SUB: begin b_eff = ~bus.src_b; cin = 1'b1;      end
            OP_ADC: cin = flags_q.c;
            OP_SBC: begin b_eff = ~bus.src_b; cin = flags_q.c; end
            default: is_arith = 1'b0;
        endcase

        sum = {1'b0, bus.src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

        unique case (op)
            OP_AND:  result_w = bus.src_a & bus.src_b;
            OP_ORR:  result_w = bus.src_a | bus.src_b;
            OP_EOR:  result_w = bus.src_a ^ bus.src_b;
            OP_MOV:  result_w = bus.src_b;
            default: result_w = sum[WIDTH-1:0];
        endcase

        alu_flags.n = result_w[WIDTH-1];
        alu_flags.z = (result_w == '0);
        // Logical ops take C from the shifter and must never disturb V.
        if (is_arith) begin
            alu_flags.c = sum[WIDTH];
            alu_flags.v = (bus.src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
        end else begin
            alu_flags.c = bus.shift_carry;
            alu_flags.v = flags_q.v;
        end
    end

    // Priority: exception entry, then return, then stall, then the normal write.
    always_comb begin
        flags_d       = flags_q;
        saved_flags_d = saved_flags_q;
        saved_valid_d = saved_valid_q;
        exc_err_d     = 1'b0;
        if (bus.exc_entry) begin
            saved_flags_d = flags_q;
            saved_valid_d = 1'b1;
        end else if (bus.exc_return) begin
            if (saved_valid_q) begin
                flags_d       = saved_flags_q;
                saved_valid_d = 1'b0;
            end else begin
                exc_err_d = 1'b1;
            end
        end else if (bus.cond_ex && !bus.stall) begin
            if (bus.flag_w[1]) begin
                flags_d.n = alu_flags.n;
                flags_d.z = alu_flags.z;
            end
            if (bus.flag_w[0]) begin
                flags_d.c = alu_flags.c;
                flags_d.v = alu_flags.v;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= RESET_FLAGS;
            saved_flags_q <= '0;
            saved_valid_q <= 1'b0;
            exc_err_q     <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            saved_flags_q <= saved_flags_d;
            saved_valid_q <= saved_valid_d;
            exc_err_q     <= exc_err_d;
        end
    end

    assign bus.result      = result_w;
    assign bus.flags       = flags_q;
    assign bus.saved_flags = saved_flags_q;
    assign bus.saved_valid = saved_valid_q;
    assign bus.exc_err     = exc_err_q;
endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed vector table, reset corner cases, then
// random traffic against an arithmetic reference model.
module tb_flag_register_unit;
    localparam int W = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        sc;
        logic [1:0]  fw;
        logic        cond, stall, entry, ret;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags, exp_saved;
        logic        exp_valid, exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flag_register_unit_if #(.WIDTH(W)) bus ();
    flag_register_unit #(.WIDTH(W), .RESET_FLAGS(4'b0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] m_flags, m_saved;
    logic       m_valid, m_err;
    vec_t       vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic sc, input logic [1:0] fw, input logic cond,
                                input logic stall, input logic entry, input logic ret,
                                input logic [31:0] er, input logic [3:0] ef, input logic [3:0] es,
                                input logic ev, input logic ee);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sc = sc; v.fw = fw; v.cond = cond;
        v.stall = stall; v.entry = entry; v.ret = ret;
        v.exp_res = er; v.exp_flags = ef; v.exp_saved = es; v.exp_valid = ev; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.alu_ctrl    = v.op;
        bus.src_a       = v.a;
        bus.src_b       = v.b;
        bus.shift_carry = v.sc;
        bus.flag_w      = v.fw;
        bus.cond_ex     = v.cond;
        bus.stall       = v.stall;
        bus.exc_entry   = v.entry;
        bus.exc_return  = v.ret;
    endtask

    // Reference ALU from signed/unsigned integer arithmetic in 64 bits.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic sc, input logic [3:0] f,
                                    output logic [31:0] r, output logic [3:0] nf);
        longint ua, ub, sa, sb, u, s, ucq;
        logic   c, v;
        bit     arith;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ucq = longint'({63'h0, f[1]});
        u = 0; s = 0; r = '0; c = sc; v = f[0]; arith = 1'b1;
        case (op)
            3'd0: begin u = ua + ub;                        s = sa + sb;             end
            3'd1: begin u = ua + (64'd4294967295 - ub) + 1; s = sa - sb;             end
            3'd6: begin u = ua + ub + ucq;                  s = sa + sb + ucq;       end
            3'd7: begin u = ua + (64'd4294967295 - ub) + ucq; s = sa - sb - 1 + ucq; end
            3'd2: begin r = a & b; arith = 1'b0; end
            3'd3: begin r = a | b; arith = 1'b0; end
            3'd4: begin r = a ^ b; arith = 1'b0; end
            default: begin r = b; arith = 1'b0; end
        endcase
        if (arith) begin
            r = u[31:0];
            c = (u >= 64'sd4294967296);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        nf = {r[31], (r == 32'h0), c, v};
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000; m_saved = 4'b0000; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input vec_t v);
        logic [31:0] r;
        logic [3:0]  nf;
        ref_alu(v.op, v.a, v.b, v.sc, m_flags, r, nf);
        m_err = 1'b0;
        if (v.entry) begin
            m_saved = m_flags;
            m_valid = 1'b1;
        end else if (v.ret) begin
            if (m_valid) begin
                m_flags = m_saved;
                m_valid = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (v.cond && !v.stall) begin
            if (v.fw[1]) m_flags[3:2] = nf[3:2];
            if (v.fw[0]) m_flags[1:0] = nf[1:0];
        end
    endtask

    // One cycle: drive at posedge+1, check result mid-cycle, check state at next posedge+1.
    task automatic cycle_model(input vec_t v, input string tag);
        logic [31:0] r;
        logic [3:0]  nf;
        drive(v);
        #2;
        ref_alu(v.op, v.a, v.b, v.sc, m_flags, r, nf);
        check({tag, "_result"}, bus.result, r);
        @(posedge clk);
        model_step(v);
        #1;
        check({tag, "_flags"}, 32'(bus.flags), 32'(m_flags));
        check({tag, "_saved"}, 32'(bus.saved_flags), 32'(m_saved));
        check({tag, "_valid"}, 32'(bus.saved_valid), 32'(m_valid));
        check({tag, "_err"}, 32'(bus.exc_err), 32'(m_err));
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t v;
        vec_t idle;
        //             op    a             b             sc  fw    c  s  en rt  result        flags    saved    v  e
        vecs[0]  = mk(3'd1, 32'd5,        32'd5,        0, 2'b11, 1, 0, 0, 0, 32'h0,        4'b0110, 4'b0000, 0, 0);
        vecs[1]  = mk(3'd0, 32'h7FFFFFFF, 32'd1,        0, 2'b11, 1, 0, 0, 0, 32'h80000000, 4'b1001, 4'b0000, 0, 0);
        vecs[2]  = mk(3'd0, 32'hFFFFFFFF, 32'd1,        0, 2'b01, 1, 0, 0, 0, 32'h0,        4'b1010, 4'b0000, 0, 0);
        vecs[3]  = mk(3'd1, 32'd0,        32'd1,        0, 2'b11, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b1010, 4'b0000, 0, 0);
        vecs[4]  = mk(3'd1, 32'd0,        32'd1,        0, 2'b11, 1, 1, 0, 0, 32'hFFFFFFFF, 4'b1010, 4'b0000, 0, 0);
        vecs[5]  = mk(3'd1, 32'd0,        32'd1,        0, 2'b11, 1, 0, 0, 0, 32'hFFFFFFFF, 4'b1000, 4'b0000, 0, 0);
        vecs[6]  = mk(3'd0, 32'h7FFFFFFF, 32'd1,        0, 2'b11, 1, 0, 0, 0, 32'h80000000, 4'b1001, 4'b0000, 0, 0);
        vecs[7]  = mk(3'd2, 32'hF0,       32'h0F,       1, 2'b11, 1, 0, 0, 0, 32'h0,        4'b0111, 4'b0000, 0, 0);
        vecs[8]  = mk(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2'b11, 1, 0, 0, 0, 32'hFFFFFFFE, 4'b1010, 4'b0000, 0, 0);
        vecs[9]  = mk(3'd0, 32'd1,        32'd1,        0, 2'b11, 1, 0, 1, 0, 32'd2,        4'b1010, 4'b1010, 1, 0);
        vecs[10] = mk(3'd0, 32'd0,        32'd0,        0, 2'b11, 1, 0, 0, 0, 32'h0,        4'b0100, 4'b1010, 1, 0);
        vecs[11] = mk(3'd5, 32'd0,        32'd0,        0, 2'b11, 1, 0, 0, 1, 32'h0,        4'b1010, 4'b1010, 0, 0);
        vecs[12] = mk(3'd5, 32'd0,        32'd0,        0, 2'b11, 1, 0, 0, 1, 32'h0,        4'b1010, 4'b1010, 0, 1);
        vecs[13] = mk(3'd5, 32'd0,        32'd0,        0, 2'b00, 1, 0, 0, 0, 32'h0,        4'b1010, 4'b1010, 0, 0);
        vecs[14] = mk(3'd0, 32'd0,        32'd0,        0, 2'b11, 1, 1, 1, 1, 32'h0,        4'b1010, 4'b1010, 1, 0);
        vecs[15] = mk(3'd6, 32'd1,        32'd2,        0, 2'b11, 1, 0, 0, 0, 32'd4,        4'b0000, 4'b1010, 1, 0);
        vecs[16] = mk(3'd7, 32'd5,        32'd3,        0, 2'b11, 1, 0, 0, 0, 32'd1,        4'b0010, 4'b1010, 1, 0);
        vecs[17] = mk(3'd4, 32'hA5,       32'hA5,       0, 2'b10, 1, 0, 0, 0, 32'h0,        4'b0110, 4'b1010, 1, 0);
        vecs[18] = mk(3'd3, 32'h00F0,     32'h0F00,     1, 2'b11, 1, 0, 0, 0, 32'h0FF0,     4'b0010, 4'b1010, 1, 0);
        vecs[19] = mk(3'd5, 32'h12345678, 32'h80000000, 0, 2'b11, 1, 0, 0, 0, 32'h80000000, 4'b1000, 4'b1010, 1, 0);
        vecs[20] = mk(3'd0, 32'd0,        32'd0,        0, 2'b11, 1, 0, 1, 0, 32'h0,        4'b1000, 4'b1000, 1, 0);
        vecs[21] = mk(3'd7, 32'h80000000, 32'd1,        0, 2'b11, 1, 0, 0, 0, 32'h7FFFFFFE, 4'b0011, 4'b1000, 1, 0);
        vecs[22] = mk(3'd5, 32'd0,        32'd0,        0, 2'b11, 1, 0, 0, 1, 32'h0,        4'b1000, 4'b1000, 0, 0);
        idle     = mk(3'd5, 32'd0,        32'd0,        0, 2'b00, 0, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 0);

        rst_n = 1'b0;
        drive(idle);
        #12;
        check("reset_flags", 32'(bus.flags), 32'h0);
        check("reset_saved", 32'(bus.saved_flags), 32'h0);
        check("reset_valid", 32'(bus.saved_valid), 32'h0);
        check("reset_err", 32'(bus.exc_err), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp_res);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_flags", i), 32'(bus.flags), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_saved", i), 32'(bus.saved_flags), 32'(vecs[i].exp_saved));
            check($sformatf("vec%0d_valid", i), 32'(bus.saved_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err", i), 32'(bus.exc_err), 32'(vecs[i].exp_err));
        end

        // Mid-cycle asynchronous reset must clear a live saved copy immediately.
        drive(mk(3'd0, 32'd0, 32'd0, 0, 2'b00, 1, 0, 1, 0, 32'h0, 4'b0, 4'b0, 0, 0));
        @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(bus.saved_valid), 32'h1);
        drive(idle);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_flags", 32'(bus.flags), 32'h0);
        check("async_reset_saved", 32'(bus.saved_flags), 32'h0);
        check("async_reset_valid", 32'(bus.saved_valid), 32'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
        // First edge after reset release performs a real write.
        cycle_model(vecs[0], "post_reset");
        check("post_reset_flags_const", 32'(bus.flags), 32'h6);

        for (int i = 0; i < 2000; i++) begin
            v.op    = 3'($urandom_range(0, 7));
            v.a     = rand_opnd();
            v.b     = rand_opnd();
            v.sc    = 1'($urandom_range(0, 1));
            v.fw    = 2'($urandom_range(0, 3));
            v.cond  = ($urandom_range(0, 3) != 0);
            v.stall = ($urandom_range(0, 4) == 0);
            v.entry = ($urandom_range(0, 9) == 0);
            v.ret   = ($urandom_range(0, 7) == 0);
            cycle_model(v, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/flag_register_unit.md
Name: flag_register_unit

Overview:
- Producer side of the condition-code interface: computes N, Z, C, V from the ALU operation and holds them in the architectural flags register.
- The condition checker consumes the registered flags.
- Flag writes are gated by the condition-check outcome (cond_ex) and by per-group write enables (flag_w).
- A one-deep saved-flags register supports exception entry and return.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- RESET_FLAGS, 4'b0000, reset value of the flags register {N,Z,C,V}.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- alu_ctrl  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV(src_b), 110 ADC, 111 SBC.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B (post-shifter).
- shift_carry  input  1  shifter carry-out, used as C for logical ops.
- flag_w  input  2  [1] writes the N,Z group; [0] writes the C,V group.
- cond_ex  input  1  condition-check pass for the current instruction.
- stall  input  1  freezes normal flag writes.
- exc_entry  input  1  one-cycle pulse: save flags.
- exc_return  input  1  one-cycle pulse: restore flags.
- result  output  WIDTH  combinational ALU result.
- flags  output  4  registered {N,Z,C,V}, drives the condition checker.
- saved_flags  output  4  registered saved copy.
- saved_valid  output  1  saved copy holds live data.
- exc_err  output  1  registered one-cycle pulse on an illegal exception return.

Behaviour:
- Reset (rst_n=0, async): flags=RESET_FLAGS, saved_flags=0, saved_valid=0, exc_err=0. result stays combinational.
- Arithmetic is done at WIDTH+1 bits.
  - ADD: A+B.
  - SUB: A+~B+1.
  - ADC: A+B+Cq, where Cq is the registered C.
  - SBC: A+~B+Cq.
  - For these ops, next C = bit WIDTH of the sum (SUB C=1 means no borrow).
  - For these ops, next V = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the operand actually added.
- Logical ops (AND, ORR, EOR, MOV): next C = shift_carry; V is unchanged even when flag_w[0]=1.
- In all ops, next N = result[WIDTH-1] and next Z = (result==0).
- Normal write, evaluated on the rising edge:
  - It applies when cond_ex=1, stall=0, exc_entry=0 and exc_return=0.
  - flag_w[1] updates N,Z; flag_w[0] updates C (and V for arithmetic ops).
  - The groups are independent. flag_w=00 leaves flags unchanged.
- Latency: new flags are visible on `flags` one cycle after the write edge. There is no combinational bypass.
- Exception entry (exc_entry=1, independent of stall and cond_ex):
  - saved_flags <= flags (the pre-edge value); saved_valid <= 1.
  - The normal write is suppressed that cycle.
  - An entry while saved_valid=1 overwrites the saved copy (one-deep, no nesting).
- Exception return (exc_return=1, exc_entry=0, independent of stall):
  - If saved_valid=1: flags <= saved_flags; saved_valid <= 0.
  - If saved_valid=0: flags unchanged; exc_err=1 for exactly one cycle.
  - The normal write is suppressed in both cases.
- exc_entry and exc_return in the same cycle: entry wins, return is ignored, and no exc_err is raised.
- Priority: reset > exc_entry > exc_return > stall > normal write.
- stall=1 holds flags, except that exception events still act.
- exc_err is 0 in every cycle without an illegal return.
- Reset asserted mid-operation clears everything immediately, including any pending saved state. The first edge after rst_n deasserts may perform a write.

Test Plan:
- Reset values: rst_n low, then high → flags=0000, saved_valid=0, exc_err=0.
- SUB equal operands: SUB A=5, B=5, flag_w=11, cond_ex=1 → result=0; flags next cycle N=0, Z=1, C=1, V=0.
- ADD signed overflow, then independent group write:
  - ADD A=0x7FFFFFFF, B=1, flag_w=11 → result=0x80000000; N=1, Z=0, C=0, V=1.
  - Then ADD A=0xFFFFFFFF, B=1, flag_w=01 → C=1, V=0; N=1, Z=0 retained.
- Gating by cond_ex and stall:
  - SUB A=0, B=1 with cond_ex=0 → flags unchanged.
  - Repeat with cond_ex=1 and stall=1 → unchanged.
  - Repeat with stall=0 → N=1, C=0 (borrow).
- Logical op keeps V: with V=1, AND A=0xF0, B=0x0F, shift_carry=1, flag_w=11 → Z=1, C=1, V stays 1.
- Exception save/restore and illegal return:
  - flags=1010, exc_entry → saved_flags=1010, saved_valid=1.
  - ADD overwrites flags to 0100.
  - exc_return → flags=1010, saved_valid=0.
  - Second exc_return → flags unchanged, exc_err high exactly one cycle.
  - exc_entry and exc_return together → save only.
